alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//   Parametrised, registered ALU with an iterative multiply/divide engine and HI/LO registers.
//   Executes 1-cycle logic/arith/shift ops plus multi-cycle MULT/MULTU/DIV/DIVU.
//   Sits in the EX stage of the MIPS datapath; the controller stalls on ready=0.
// PARAMETERS
//   WIDTH     32  operand/result width; must be a power of two and >= 8
//   SHAMT_W   $clog2(WIDTH)  shift-amount width, derived; do not override
// PORTS
//   clk          in   1      clock; all state updates on the rising edge
//   reset_n      in   1      asynchronous, active-low reset
//   start        in   1      op request; accepted only when ready=1
//   aluControl   in   4      operation code (see BEHAVIOUR)
//   srcA         in   WIDTH  operand A
//   srcB         in   WIDTH  operand B; shift ops use srcB[SHAMT_W-1:0]
//   ready        out  1      1 = idle, can accept start
//   result_valid out  1      1-cycle pulse; aluOut/flags valid in that cycle and held after
//   aluOut       out  WIDTH  registered result (LO for mul/div)
//   zero         out  1      (aluOut == 0), derived from the aluOut register
//   overflow     out  1      signed overflow of add/sub; 0 for all other ops
//   div_by_zero  out  1      set with result_valid on DIV/DIVU with srcB==0
//   illegal      out  1      set with result_valid on an unused code
//   hi, lo       out  WIDTH  HI/LO registers; change only on mul/div completion
// BEHAVIOUR
//   Reset (async, reset_n=0): ready=1, result_valid=0, aluOut/hi/lo=0, zero=1, all flags=0,
//     FSM->IDLE, counter=0. Reset mid-operation aborts it; no result_valid is issued.
//   Codes: 0000 and, 0001 or, 0010 add, 0011 xor, 0100 nor, 0101 sltu, 0110 sub,
//     0111 slt (signed), 1000 sll, 1001 srl, 1010 sra, 1011 illegal,
//     1100 multu, 1101 mult, 1110 divu, 1111 div.
//   1-cycle ops: start&ready at edge N -> aluOut/flags registered at N, result_valid=1
//     for cycle N..N+1. ready stays 1, so back-to-back ops are legal every cycle.
//   Illegal code: aluOut=0, illegal=1, 1-cycle latency.
//   add/sub wrap modulo 2^WIDTH; overflow = operand sign rule. slt/sltu produce 0 or 1.
//   Shifts use only the low SHAMT_W bits of srcB; upper bits are ignored.
//   FSM: IDLE -> BUSY (WIDTH cycles: one shift-add or restoring-subtract step each)
//     -> FIX (sign correction, HI/LO write) -> IDLE with result_valid=1.
//     ready=0 from the accept edge until FIX exits. Total latency = WIDTH+2 edges.
//   start while ready=0 is ignored; it is neither queued nor reported as an error.
//   Signed mul/div: operate on magnitudes; product sign = sA^sB, quotient sign = sA^sB,
//     remainder sign = sA. Mul: {hi,lo} = full 2*WIDTH product. Div: lo=quot, hi=rem.
//   DIV MIN/-1: lo=MIN (wraps), hi=0, no flag.
//   Divide by zero: skip BUSY, go straight to FIX; lo=all ones, hi=srcA, div_by_zero=1.
//     Latency is 2 edges.
//   aluOut=lo on mul/div completion. overflow=0 on mul/div.
//   Operands are latched at accept; later srcA/srcB/aluControl changes have no effect.
// STRUCTURE
//   alu_pkg: localparams for the 4-bit op codes, FSM state encoding (IDLE/BUSY/FIX),
//     and the helper function is_muldiv(op).
//   Sub-module muldiv_iter: owns the iterative engine (acc, operand regs, counter, sign fix).
//     Interface: go, signed_op, is_div, a, b -> done, hi_out, lo_out, dbz.
//   alu_seq: 1-cycle datapath, output regs, top-level ready/result_valid.
// TESTING
//   Reset: assert reset_n=0 mid-MULT -> ready=1, hi=lo=aluOut=0, zero=1, no result_valid.
//   WIDTH=32, add 0x7FFFFFFF+1 -> aluOut=0x80000000, overflow=1, result_valid after 1 cycle.
//     sub 5-5 -> aluOut=0, zero=1.
//   slt -1,1 -> 1; sltu -1,1 -> 0; sra 0x80000000,srcB=0x24 (shamt 4) -> 0xF8000000.
//   mult -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB at edge 34; multu 0xFFFFFFFF^2
//     -> hi=0xFFFFFFFE, lo=1; ready=0 for 34 cycles; start mid-op ignored.
//   div -7/2 -> lo=-3 (0xFFFFFFFD), hi=-1; divu 7/0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1,
//     latency 2.
//   div 0x80000000/-1 -> lo=0x80000000, hi=0.
//   Code 1011 -> illegal=1, aluOut=0.
//   Repeat the mul/div subset at WIDTH=8.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   - 4-bit operation codes driven on aluControl
//   - state encoding for the iterative multiply/divide engine
//   - is_muldiv(): true for the four multi-cycle codes (11xx)
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_ILL  = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_MULT  = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_DIV   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Multi-cycle ops share the 11xx prefix; bit0 = signed, bit1 = divide.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine.
//   One shift-add (multiply) or restoring-subtract (divide) step per BUSY
//   cycle on unsigned magnitudes, then a FIX cycle that applies the result
//   signs. done is high during FIX; hi_out/lo_out/dbz are valid while done.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   go                 accept a new operation (only honoured when idle)
//   signed_op, is_div  operation kind, sampled with go
//   a, b               operands, sampled with go
//   done               high for the single FIX cycle
//   idle               engine can accept go
//   dbz                divide by zero (valid with done)
//   hi_out, lo_out     corrected HI/LO (valid with done)
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic             signed_op,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic             idle,
  output logic             dbz,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  import alu_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] acc_reg;   // upper half: partial product / partial remainder
  logic [WIDTH-1:0] q_reg;     // lower half: multiplier bits / quotient bits
  logic [WIDTH-1:0] m_reg;     // multiplicand or divisor magnitude
  logic [CNT_W-1:0] cnt_reg;
  logic             is_div_reg, neg_q_reg, neg_r_reg, dbz_reg;

  logic             sign_a, sign_b, b_zero;
  logic [WIDTH-1:0] mag_a, mag_b, addend;
  logic [WIDTH:0]   add_sum, shl, trial;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;

  assign sign_a = signed_op & a[WIDTH-1];
  assign sign_b = signed_op & b[WIDTH-1];
  assign mag_a  = sign_a ? -a : a;
  assign mag_b  = sign_b ? -b : b;
  assign b_zero = (b == '0);

  // Multiply step: add multiplicand when the current multiplier bit is set,
  // then shift {acc,q} right by one (the carry enters acc's MSB).
  assign addend  = q_reg[0] ? m_reg : '0;
  assign add_sum = {1'b0, acc_reg} + {1'b0, addend};

  // Divide step: shift {acc,q} left, trial-subtract divisor. Because the
  // partial remainder is always below the divisor, bit WIDTH of the
  // difference is exactly the borrow.
  assign shl   = {acc_reg, q_reg[WIDTH-1]};
  assign trial = shl - {1'b0, m_reg};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (go) state_next = (is_div && b_zero) ? ST_FIX : ST_BUSY;
      ST_BUSY: if (cnt_reg == LAST_STEP) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg    <= '0;
      q_reg      <= '0;
      m_reg      <= '0;
      cnt_reg    <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dbz_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (go) begin
            cnt_reg    <= '0;
            is_div_reg <= is_div;
            if (is_div && b_zero) begin
              // Preload the final answer; clearing the sign flags makes
              // FIX pass it through unchanged.
              acc_reg   <= a;
              q_reg     <= '1;
              m_reg     <= '0;
              neg_q_reg <= 1'b0;
              neg_r_reg <= 1'b0;
              dbz_reg   <= 1'b1;
            end else begin
              acc_reg   <= '0;
              q_reg     <= mag_a;
              m_reg     <= mag_b;
              neg_q_reg <= sign_a ^ sign_b;
              neg_r_reg <= sign_a;
              dbz_reg   <= 1'b0;
            end
          end
        end
        ST_BUSY: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (is_div_reg) begin
            if (!trial[WIDTH]) begin
              acc_reg <= trial[WIDTH-1:0];
              q_reg   <= {q_reg[WIDTH-2:0], 1'b1};
            end else begin
              acc_reg <= shl[WIDTH-1:0];
              q_reg   <= {q_reg[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_reg <= add_sum[WIDTH:1];
            q_reg   <= {add_sum[0], q_reg[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Sign correction. MIN/-1 naturally wraps: magnitude 2^(WIDTH-1) negated
  // in WIDTH bits is MIN again.
  assign prod_mag = {acc_reg, q_reg};
  assign prod_fix = neg_q_reg ? -prod_mag : prod_mag;

  always_comb begin
    hi_out = prod_fix[2*WIDTH-1:WIDTH];
    lo_out = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      lo_out = neg_q_reg ? -q_reg : q_reg;
      hi_out = neg_r_reg ? -acc_reg : acc_reg;
    end
  end

  assign done = (state_reg == ST_FIX);
  assign idle = (state_reg == ST_IDLE);
  assign dbz  = dbz_reg;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with iterative multiply/divide and HI/LO registers.
//   Single-cycle ops register their result on the accept edge; mul/div run
//   in muldiv_iter and register on the edge that leaves FIX.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start, aluControl            op request and code (taken when ready=1)
//   srcA, srcB                   operands (shifts use srcB[SHAMT_W-1:0])
//   ready                        idle, can accept start
//   result_valid                 one-cycle pulse per completed op
//   aluOut, zero                 registered result and its zero flag
//   overflow, div_by_zero, illegal  status flags, held until next result
//   hi, lo                       HI/LO registers (mul/div only)
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       aluControl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             ready,
  output logic             result_valid,
  output logic [WIDTH-1:0] aluOut,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import alu_pkg::*;

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sum, diff, alu_res;
  logic               alu_ov, alu_ill, accept, op_md;
  logic               md_done, md_idle, md_dbz;
  logic [WIDTH-1:0]   md_hi, md_lo;

  logic [WIDTH-1:0]   aluout_reg, hi_reg, lo_reg;
  logic               result_valid_reg, overflow_reg, dbz_reg, illegal_reg;

  assign shamt  = srcB[SHAMT_W-1:0];
  assign sum    = srcA + srcB;
  assign diff   = srcA - srcB;
  assign op_md  = is_muldiv(aluControl);
  assign accept = start & ready;

  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    alu_ill = 1'b0;
    case (aluControl)
      OP_AND:  alu_res = srcA & srcB;
      OP_OR:   alu_res = srcA | srcB;
      OP_ADD: begin
        alu_res = sum;
        alu_ov  = (srcA[WIDTH-1] == srcB[WIDTH-1]) && (sum[WIDTH-1] != srcA[WIDTH-1]);
      end
      OP_XOR:  alu_res = srcA ^ srcB;
      OP_NOR:  alu_res = ~(srcA | srcB);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
      OP_SUB: begin
        alu_res = diff;
        alu_ov  = (srcA[WIDTH-1] != srcB[WIDTH-1]) && (diff[WIDTH-1] != srcA[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      OP_SLL:  alu_res = srcA << shamt;
      OP_SRL:  alu_res = srcA >> shamt;
      OP_SRA:  alu_res = $signed(srcA) >>> shamt;
      OP_ILL:  alu_ill = 1'b1;
      default: ;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .reset_n   (reset_n),
    .go        (accept & op_md),
    .signed_op (aluControl[0]),
    .is_div    (aluControl[1]),
    .a         (srcA),
    .b         (srcB),
    .done      (md_done),
    .idle      (md_idle),
    .dbz       (md_dbz),
    .hi_out    (md_hi),
    .lo_out    (md_lo)
  );

  // The engine is busy from the accept edge until FIX exits, which is
  // exactly when single-cycle ops must also be held off.
  assign ready = md_idle;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aluout_reg       <= '0;
      hi_reg           <= '0;
      lo_reg           <= '0;
      result_valid_reg <= 1'b0;
      overflow_reg     <= 1'b0;
      dbz_reg          <= 1'b0;
      illegal_reg      <= 1'b0;
    end else begin
      result_valid_reg <= 1'b0;
      if (md_done) begin
        hi_reg           <= md_hi;
        lo_reg           <= md_lo;
        aluout_reg       <= md_lo;
        overflow_reg     <= 1'b0;
        dbz_reg          <= md_dbz;
        illegal_reg      <= 1'b0;
        result_valid_reg <= 1'b1;
      end else if (accept && !op_md) begin
        aluout_reg       <= alu_res;
        overflow_reg     <= alu_ov;
        dbz_reg          <= 1'b0;
        illegal_reg      <= alu_ill;
        result_valid_reg <= 1'b1;
      end
    end
  end

  assign result_valid = result_valid_reg;
  assign aluOut       = aluout_reg;
  assign zero         = (aluout_reg == '0);
  assign overflow     = overflow_reg;
  assign div_by_zero  = dbz_reg;
  assign illegal      = illegal_reg;
  assign hi           = hi_reg;
  assign lo           = lo_reg;

endmodule
